// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states, burst-mode test.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Only the shift/rotate family can be repeated by the burst engine.
  function automatic logic is_burst_mode(mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the shift register: selected operation applied to the current value.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  output logic [WIDTH-1:0] o_q_c
);

  // Next-value mux over the eight operations.
  always_comb begin
    o_q_c = i_q;
    case (i_mode)
      MODE_HOLD:  o_q_c = i_q;
      MODE_SHR:   o_q_c = {i_sin_l, i_q[WIDTH-1:1]};
      MODE_SHL:   o_q_c = {i_q[WIDTH-2:0], i_sin_r};
      MODE_LOAD:  o_q_c = i_d;
      MODE_ROR:   o_q_c = {i_q[0], i_q[WIDTH-1:1]};
      MODE_ROL:   o_q_c = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_ASR:   o_q_c = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
      MODE_CLEAR: o_q_c = '0;
      default:    o_q_c = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with manual per-cycle operations and an N-step auto-shift burst engine.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_nxt;
  mode_e            r_mode;
  mode_e            w_mode_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  mode_e            w_live_mode;
  mode_e            w_step_mode;
  logic [WIDTH-1:0] w_step_q;

  assign w_live_mode = mode_e'(mode);

  // While bursting the captured mode drives the step; otherwise the live mode does.
  assign w_step_mode = (r_state == RUN) ? r_mode : w_live_mode;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mode (w_step_mode),
    .i_q    (r_q),
    .i_d    (d),
    .i_sin_l(sin_l),
    .i_sin_r(sin_r),
    .o_q_c  (w_step_q)
  );

  // State, counter, captured mode, data and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: burst acceptance in IDLE, step countdown in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && is_burst_mode(w_live_mode)) begin
          // Accepting edge never shifts; a zero-length burst completes immediately.
          if (nshift != '0) begin
            w_state_nxt = RUN;
            w_mode_nxt  = w_live_mode;
            w_cnt_nxt   = nshift;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (en) begin
          w_q_nxt = w_step_q;
        end
      end
      RUN: begin
        if (en) begin
          w_q_nxt   = w_step_q;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus randomized model comparison.
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [CNT_W-1:0] nshift;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] m_q;
  logic       m_busy;
  logic       m_done;
  int         m_left;
  int         m_mode;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .start (start),
    .nshift(nshift),
    .q     (q),
    .sout_r(sout_r),
    .sout_l(sout_l),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operation results computed with integer arithmetic on an 8-bit value.
  function automatic logic [7:0] model_op(int m, logic [7:0] qv, logic sl, logic sr, logic [7:0] dv);
    int x;
    x = int'(qv);
    case (m)
      1: x = (x / 2) + (sl ? 128 : 0);
      2: x = ((x * 2) % 256) + (sr ? 1 : 0);
      3: x = int'(dv);
      4: x = (x / 2) + ((x % 2) * 128);
      5: x = ((x * 2) % 256) + (x / 128);
      6: x = (x / 2) + ((x >= 128) ? 128 : 0);
      7: x = 0;
      default: x = int'(qv);
    endcase
    return 8'(x);
  endfunction

  function automatic bit is_burst(int m);
    return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
  endfunction

  // Advance one clock; the model consumes the inputs that were present at the edge.
  task automatic tick();
    logic [7:0] nq;
    bit nb, nd;
    int nl, nm;
    nq = m_q; nb = m_busy; nd = 1'b0; nl = m_left; nm = m_mode;
    if (!m_busy) begin
      if (start && is_burst(int'(mode))) begin
        if (nshift != 0) begin
          nb = 1'b1; nl = int'(nshift); nm = int'(mode);
        end else begin
          nd = 1'b1;
        end
      end else if (en) begin
        nq = model_op(int'(mode), m_q, sin_l, sin_r, d);
      end
    end else if (en) begin
      nq = model_op(m_mode, m_q, sin_l, sin_r, d);
      nl = nl - 1;
      if (nl == 0) begin
        nb = 1'b0; nd = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_busy = nb; m_done = nd; m_left = nl; m_mode = nm;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_mode = 0;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    en = 1'b1; start = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0; nshift = '0;
  endtask

  task automatic load(logic [7:0] v);
    idle_inputs();
    mode = 3'd3; d = v;
    tick();
    mode = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    n_tests++;
    if ({q, sout_r, sout_l, busy, done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: q=%h sr=%b sl=%b busy=%b done=%b, required all 0", q, sout_r, sout_l, busy, done);
    end
    do_reset();
  endtask

  task automatic test_manual();
    load(8'hA5);
    n_tests++;
    if (q !== 8'hA5) begin n_fail++; $display("FAIL manual_load: q=%h required a5", q); end
    mode = 3'd1; sin_l = 1'b1; tick();
    n_tests++;
    if (q !== 8'hD2) begin n_fail++; $display("FAIL manual_shr: q=%h required d2", q); end
    mode = 3'd2; sin_l = 1'b0; sin_r = 1'b0; tick();
    n_tests++;
    if (q !== 8'hA4) begin n_fail++; $display("FAIL manual_shl: q=%h required a4", q); end
    en = 1'b0; mode = 3'd7; tick(); tick();
    n_tests++;
    if (q !== 8'hA4) begin n_fail++; $display("FAIL manual_hold_en0: q=%h required a4", q); end
  endtask

  task automatic test_rotate_arith();
    load(8'h81);
    mode = 3'd4; tick();
    n_tests++;
    if (q !== 8'hC0) begin n_fail++; $display("FAIL ror: q=%h required c0", q); end
    load(8'h81);
    mode = 3'd5; tick();
    n_tests++;
    if (q !== 8'h03) begin n_fail++; $display("FAIL rol: q=%h required 03", q); end
    n_tests++;
    if ({sout_l, sout_r} !== 2'b01) begin n_fail++; $display("FAIL sout_rol: sl=%b sr=%b required 0 1", sout_l, sout_r); end
    load(8'h80);
    mode = 3'd6; tick();
    n_tests++;
    if (q !== 8'hC0) begin n_fail++; $display("FAIL asr: q=%h required c0", q); end
    n_tests++;
    if ({sout_l, sout_r} !== 2'b10) begin n_fail++; $display("FAIL sout_asr: sl=%b sr=%b required 1 0", sout_l, sout_r); end
    mode = 3'd7; tick();
    n_tests++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL clear: q=%h required 00", q); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [3] = '{8'h02, 8'h04, 8'h08};
    load(8'h01);
    start = 1'b1; mode = 3'd5; nshift = 4'd3; tick();
    start = 1'b0; mode = 3'd0;
    n_tests++;
    if ({busy, done, q} !== {2'b10, 8'h01}) begin
      n_fail++; $display("FAIL burst_accept: busy=%b done=%b q=%h required 1 0 01", busy, done, q);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({busy, done, q} !== {(i < 2), (i == 2), exp_q[i]}) begin
        n_fail++; $display("FAIL burst_step%0d: busy=%b done=%b q=%h required %b %b %h", i, busy, done, q, i < 2, i == 2, exp_q[i]);
      end
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL burst_done_once: done=%b required 0", done); end
  endtask

  task automatic test_pause_ignore();
    int dones;
    load(8'h01);
    start = 1'b1; mode = 3'd5; nshift = 4'd3; tick();
    start = 1'b0; tick();
    en = 1'b0; start = 1'b1; mode = 3'd3; d = 8'hFF; nshift = 4'd1;
    tick(); tick();
    n_tests++;
    if ({busy, done, q} !== {2'b10, 8'h02}) begin
      n_fail++; $display("FAIL pause_frozen: busy=%b done=%b q=%h required 1 0 02", busy, done, q);
    end
    en = 1'b1; tick();
    start = 1'b0; mode = 3'd0;
    n_tests++;
    if ({busy, done, q} !== {2'b10, 8'h04}) begin
      n_fail++; $display("FAIL ignore_live_load: busy=%b done=%b q=%h required 1 0 04", busy, done, q);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 1 || q !== 8'h08 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pause_finish: dones=%0d q=%h busy=%b required 1 08 0", dones, q, busy);
    end
  endtask

  task automatic test_edge_starts();
    load(8'h3C);
    start = 1'b1; mode = 3'd4; nshift = 4'd0; tick();
    start = 1'b0;
    n_tests++;
    if ({busy, done, q} !== {2'b01, 8'h3C}) begin
      n_fail++; $display("FAIL nshift0: busy=%b done=%b q=%h required 0 1 3c", busy, done, q);
    end
    mode = 3'd0; tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL nshift0_pulse: busy=%b done=%b required 0 0", busy, done); end
    start = 1'b1; mode = 3'd3; d = 8'h5A; nshift = 4'd3; tick();
    start = 1'b0; mode = 3'd0;
    n_tests++;
    if ({busy, done, q} !== {2'b00, 8'h5A}) begin
      n_fail++; $display("FAIL start_load: busy=%b done=%b q=%h required 0 0 5a", busy, done, q);
    end
  endtask

  task automatic test_reset_mid_burst();
    int dones;
    load(8'hA5);
    start = 1'b1; mode = 3'd4; nshift = 4'd8; tick();
    start = 1'b0; mode = 3'd0;
    tick(); tick(); tick();
    n_tests++;
    if (q !== 8'hB4) begin n_fail++; $display("FAIL ror_three_steps: q=%h required b4", q); end
    do_reset();
    n_tests++;
    if ({busy, done, q} !== 10'h000) begin
      n_fail++; $display("FAIL reset_abort: busy=%b done=%b q=%h required 0 0 00", busy, done, q);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL no_pending_done: busy/done cycles=%0d required 0", dones); end
    load(8'hA5);
    start = 1'b1; mode = 3'd4; nshift = 4'd8; tick();
    start = 1'b0; mode = 3'd0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 1 || q !== 8'hA5) begin
      n_fail++; $display("FAIL ror8_full: dones=%0d q=%h required 1 a5", dones, q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en     = ($urandom_range(0, 9) < 8);
      start  = ($urandom_range(0, 3) == 0);
      mode   = 3'($urandom_range(0, 7));
      d      = 8'($urandom);
      sin_l  = 1'($urandom);
      sin_r  = 1'($urandom);
      nshift = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        tick();
      end
      n_tests++;
      if ({q, sout_r, sout_l, busy, done} !== {m_q, m_q[0], m_q[7], m_busy, m_done}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: q=%h sr=%b sl=%b busy=%b done=%b required %h %b %b %b %b",
                 i, q, sout_r, sout_l, busy, done, m_q, m_q[0], m_q[7], m_busy, m_done);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_mode = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_manual();
    test_rotate_arith();
    test_burst();
    test_pause_ignore();
    test_edge_starts();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
